// File: rtl/gcd_req_sequencer.sv
// Request sequencer in front of the GCD core: buffers operand pairs, issues them one at a time,
// and returns each result with its operands (zero operands bypass the core; a hung core times out).
module gcd_req_sequencer #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [WIDTH-1:0]         req_a_i,
  input  logic [WIDTH-1:0]         req_b_i,
  output logic                     gcd_valid_o,
  output logic [WIDTH-1:0]         gcd_a_o,
  output logic [WIDTH-1:0]         gcd_b_o,
  input  logic [WIDTH-1:0]         gcd_result_i,
  input  logic                     gcd_done_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [WIDTH-1:0]         rsp_a_o,
  output logic [WIDTH-1:0]         rsp_b_o,
  output logic [WIDTH-1:0]         rsp_gcd_o,
  output logic                     rsp_err_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [TW-1:0]    timer;
  logic             push;
  logic             pop;
  logic             empty;
  logic             head_zero;
  logic [WIDTH-1:0] head_a;
  logic [WIDTH-1:0] head_b;

  assign empty       = (count == '0);
  assign req_ready_o = (count != FULL_COUNT);
  assign count_o     = count;
  assign push        = req_valid_i && req_ready_o;
  assign head_a      = mem_a[rd_ptr];
  assign head_b      = mem_b[rd_ptr];
  assign head_zero   = (head_a == '0) || (head_b == '0);
  // The FIFO is only popped by the FSM: on issue, or directly from IDLE for a zero operand.
  assign pop         = (state == ISSUE) || ((state == IDLE) && !empty && head_zero);

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_a[wr_ptr] <= req_a_i;
      mem_b[wr_ptr] <= req_b_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // gcd_valid_o is registered so it is high exactly while the FSM sits in ISSUE.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      timer       <= '0;
      gcd_valid_o <= 1'b0;
      gcd_a_o     <= '0;
      gcd_b_o     <= '0;
      rsp_valid_o <= 1'b0;
      rsp_a_o     <= '0;
      rsp_b_o     <= '0;
      rsp_gcd_o   <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            if (head_zero) begin
              rsp_a_o     <= head_a;
              rsp_b_o     <= head_b;
              rsp_gcd_o   <= head_a | head_b;
              rsp_err_o   <= 1'b0;
              rsp_valid_o <= 1'b1;
              state       <= RESP;
            end else begin
              gcd_valid_o <= 1'b1;
              gcd_a_o     <= head_a;
              gcd_b_o     <= head_b;
              state       <= ISSUE;
            end
          end
        end
        ISSUE: begin
          gcd_valid_o <= 1'b0;
          rsp_a_o     <= head_a;
          rsp_b_o     <= head_b;
          timer       <= '0;
          state       <= WAIT;
        end
        WAIT: begin
          timer <= timer + TW'(1);
          // A result arriving on the last allowed cycle still counts as success.
          if (gcd_done_i) begin
            rsp_gcd_o   <= gcd_result_i;
            rsp_err_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            state       <= RESP;
          end else if (timer == TIMER_LAST) begin
            rsp_gcd_o   <= '0;
            rsp_err_o   <= 1'b1;
            rsp_valid_o <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
